// File: rtl/ram_test_pkg.sv
// ram_test_pkg: shared RAM test geometry, pattern default and state types for the fill and verify stages
package ram_test_pkg;
  localparam int RAM_SIZE = 1048576;
  localparam int BLOCK_SIZE = 4096;
  localparam logic [31:0] DEFAULT_FIRST_DATA = 32'hC000_0000;
  typedef enum logic {AR_IDLE, AR_ISSUE} ar_state_t;
  typedef enum logic [1:0] {R_IDLE, R_CHECK, R_FINISH} r_state_t;
  function automatic int cycles_per_block(input int dw);
    return BLOCK_SIZE / (dw / 8);
  endfunction
  function automatic int max_blocks();
    return RAM_SIZE / BLOCK_SIZE;
  endfunction
endpackage

// File: rtl/ram_pattern_checker.sv
// ram_pattern_checker: compares accepted read beats against the incrementing fill pattern and tallies failures
module ram_pattern_checker #(
  parameter int DW = 512,
  parameter int AW = 20,
  parameter logic [31:0] FIRST_DATA = 32'hC000_0000,
  parameter int CPB = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic beat,
  input  logic [DW-1:0] rdata,
  input  logic [1:0] rresp,
  input  logic rlast,
  output logic [31:0] error_count,
  output logic [AW-1:0] first_err_addr
);
  localparam int BW = CPB > 1 ? $clog2(CPB) : 1;
  logic [DW-1:0] expected;
  logic [AW-1:0] beat_addr;
  logic [BW-1:0] beat_idx;
  logic last, bad;
  assign last = beat_idx == BW'(CPB - 1);
  assign bad = rdata != expected || rresp != 2'b00 || rlast != last;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      expected <= DW'(FIRST_DATA);
      beat_addr <= '0;
      beat_idx <= '0;
      error_count <= '0;
      first_err_addr <= '0;
    end else if (clear) begin
      expected <= DW'(FIRST_DATA);
      beat_addr <= '0;
      beat_idx <= '0;
      error_count <= '0;
      first_err_addr <= '0;
    end else if (beat) begin
      expected <= expected + 1'b1;
      beat_addr <= beat_addr + AW'(DW / 8);
      beat_idx <= last ? '0 : beat_idx + 1'b1;
      if (bad && error_count == '0) first_err_addr <= beat_addr;
      if (bad && error_count != '1) error_count <= error_count + 1'b1;
    end
endmodule

// File: rtl/verify_ram.sv
// verify_ram: AXI4 read master that reads back the filled RAM in 4 KiB bursts and checks it against the fill pattern
module verify_ram
  import ram_test_pkg::*;
#(
  parameter int DW = 512,
  parameter int AW = 20,
  parameter logic [31:0] FIRST_DATA = DEFAULT_FIRST_DATA,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [31:0] error_count,
  output logic [AW-1:0] first_err_addr,
  output logic [AW-1:0] M_AXI_ARADDR,
  output logic M_AXI_ARVALID,
  input  logic M_AXI_ARREADY,
  output logic [7:0] M_AXI_ARLEN,
  output logic [2:0] M_AXI_ARSIZE,
  output logic [1:0] M_AXI_ARBURST,
  output logic [3:0] M_AXI_ARID,
  output logic [3:0] M_AXI_ARCACHE,
  output logic [3:0] M_AXI_ARQOS,
  output logic M_AXI_ARLOCK,
  output logic [2:0] M_AXI_ARPROT,
  input  logic [DW-1:0] M_AXI_RDATA,
  input  logic M_AXI_RVALID,
  input  logic [1:0] M_AXI_RRESP,
  input  logic M_AXI_RLAST,
  output logic M_AXI_RREADY
);
  localparam int CPB = cycles_per_block(DW);
  localparam int MB = max_blocks();
  localparam int TOTAL = MB * CPB;
  localparam int BCW = $clog2(MB);
  localparam int TCW = $clog2(TOTAL);
  localparam int OW = 4;
  ar_state_t ar_state, ar_next;
  r_state_t r_state, r_next;
  logic [BCW-1:0] blk;
  logic [TCW-1:0] beat_cnt;
  logic [OW-1:0] outstanding, out_next;
  logic go, ar_hs, r_hs, r_end, acc, ar_last, beat_last, arvalid_next;
  assign go = start & ~busy & ~done;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs = M_AXI_RVALID & M_AXI_RREADY;
  assign r_end = r_hs & M_AXI_RLAST & (outstanding != '0);
  assign acc = r_hs & (r_state == R_CHECK);
  assign ar_last = ar_hs & (blk == BCW'(MB - 1));
  assign beat_last = acc & (beat_cnt == TCW'(TOTAL - 1));
  assign out_next = outstanding + OW'(ar_hs) - OW'(r_end);
  assign M_AXI_ARLEN = 8'(CPB - 1);
  assign M_AXI_ARSIZE = 3'($clog2(DW / 8));
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARID = '0;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARQOS = '0;
  assign M_AXI_ARLOCK = 1'b0;
  assign M_AXI_ARPROT = '0;
  assign M_AXI_RREADY = busy;
  always_comb begin
    ar_next = (ar_state == AR_IDLE && go) ? AR_ISSUE : (ar_state == AR_ISSUE && ar_last) ? AR_IDLE : ar_state;
    r_next = (r_state == R_IDLE && go) ? R_CHECK : beat_last ? R_FINISH : (r_state == R_FINISH) ? R_IDLE : r_state;
    arvalid_next = ar_next == AR_ISSUE && ((M_AXI_ARVALID && !M_AXI_ARREADY) || out_next < OW'(MAX_OUTSTANDING));
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ar_state <= AR_IDLE;
      r_state <= R_IDLE;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR <= '0;
      blk <= '0;
      outstanding <= '0;
      beat_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      ar_state <= ar_next;
      r_state <= r_next;
      M_AXI_ARVALID <= arvalid_next;
      outstanding <= out_next;
      done <= r_state == R_FINISH;
      if (go) begin
        M_AXI_ARADDR <= '0;
        blk <= '0;
        beat_cnt <= '0;
        busy <= 1'b1;
        pass <= 1'b0;
      end
      if (ar_hs) begin
        M_AXI_ARADDR <= M_AXI_ARADDR + AW'(BLOCK_SIZE);
        blk <= blk + 1'b1;
      end
      if (acc) beat_cnt <= beat_cnt + 1'b1;
      if (r_state == R_FINISH) begin
        busy <= 1'b0;
        pass <= error_count == '0;
      end
    end
  ram_pattern_checker #(.DW(DW), .AW(AW), .FIRST_DATA(FIRST_DATA), .CPB(CPB)) u_checker (
    .clk(clk),
    .resetn(resetn),
    .clear(go),
    .beat(acc),
    .rdata(M_AXI_RDATA),
    .rresp(M_AXI_RRESP),
    .rlast(M_AXI_RLAST),
    .error_count(error_count),
    .first_err_addr(first_err_addr)
  );
endmodule

// File: tb/tb_verify_ram.sv
// tb_verify_ram: AXI slave memory model plus a pass-level reference model checking verify_ram every cycle
module tb_verify_ram;
  localparam int DW = 512;
  localparam int AW = 20;
  localparam int MO = 4;
  localparam int CPB = 64;
  localparam int NB = 256;
  localparam int TOT = 16384;
  localparam logic [31:0] FD = 32'hC000_0000;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic busy, done, pass, arvalid, arready, arlock, rvalid, rlast, rready;
  logic [31:0] error_count;
  logic [AW-1:0] first_err_addr, araddr;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst, rresp;
  logic [3:0] arid, arcache, arqos;
  logic [DW-1:0] rdata;
  verify_ram #(.DW(DW), .AW(AW), .FIRST_DATA(FD), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_err_addr(first_err_addr),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
    .M_AXI_ARID(arid), .M_AXI_ARCACHE(arcache), .M_AXI_ARQOS(arqos),
    .M_AXI_ARLOCK(arlock), .M_AXI_ARPROT(arprot),
    .M_AXI_RDATA(rdata), .M_AXI_RVALID(rvalid), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(rlast), .M_AXI_RREADY(rready)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", name, got, want, $time);
    end
  endtask
  function automatic logic [DW-1:0] pat(input int a);
    return DW'(FD) + DW'(a / (DW / 8));
  endfunction
  typedef struct {int addr; int t;} burst_t;
  burst_t arq[$];
  burst_t b;
  int ready_pct = 100;
  int r_delay = 0;
  int bad_data_addr = -1;
  int bad_resp_addr = -1;
  int early_last_addr = -1;
  bit slave_rst = 1'b1;
  bit s_ar_fire, s_r_fire, r_act;
  logic [AW-1:0] s_ar_addr;
  int cyc = 0;
  int r_addr = 0;
  int r_beat = 0;
  int s_a;
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; r_act = 1'b0;
    forever begin
      @(negedge clk);
      s_ar_fire = arvalid && arready;
      s_r_fire = rvalid && rready;
      s_ar_addr = araddr;
      @(posedge clk);
      #1;
      cyc++;
      if (slave_rst) begin
        arq.delete();
        r_act = 1'b0;
      end else begin
        if (s_ar_fire) begin
          b.addr = int'(s_ar_addr);
          b.t = cyc + r_delay;
          arq.push_back(b);
        end
        if (s_r_fire) begin
          if (r_beat == CPB - 1) r_act = 1'b0;
          else r_beat++;
        end
        if (!r_act && arq.size() > 0 && arq[0].t <= cyc) begin
          r_addr = arq[0].addr;
          r_act = 1'b1;
          r_beat = 0;
          void'(arq.pop_front());
        end
      end
      s_a = r_addr + r_beat * (DW / 8);
      arready = $urandom_range(99) < ready_pct;
      rvalid = r_act;
      rdata = s_a == bad_data_addr ? DW'(32'hDEAD) : pat(s_a);
      rresp = s_a == bad_resp_addr ? 2'b10 : 2'b00;
      rlast = r_beat == CPB - 1 || s_a == early_last_addr;
    end
  end
  int ncyc = 0;
  int m_done_at = -1;
  int m_beat = 0;
  int m_ar_n = 0;
  int m_out = 0;
  int m_dones = 0;
  logic [31:0] m_err = '0;
  logic [AW-1:0] m_first = '0;
  bit m_busy = 1'b0;
  bit m_pass = 1'b0;
  bit chk_out = 1'b1;
  bit stall_q = 1'b0;
  bit m_bad;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] expd;
  always @(negedge clk) begin
    ncyc++;
    if (!resetn) begin
      m_done_at = -1; m_busy = 1'b0; m_pass = 1'b0; m_err = '0; m_first = '0;
      m_beat = 0; m_ar_n = 0; m_out = 0; stall_q = 1'b0;
    end else begin
      if (ncyc == m_done_at) begin
        m_busy = 1'b0;
        m_pass = m_err == '0;
        m_dones++;
      end
      chk("done", 64'(done), 64'(ncyc == m_done_at));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("rready", 64'(rready), 64'(m_busy));
      chk("pass", 64'(pass), 64'(m_pass));
      chk("error_count", 64'(error_count), 64'(m_err));
      chk("first_err_addr", 64'(first_err_addr), 64'(m_first));
      if (chk_out) chk("outstanding_le_max", 64'(m_out <= MO), 64'(1));
      if (stall_q) chk("araddr_stable", 64'(araddr), 64'(addr_q));
      if (arvalid && arready) begin
        chk("araddr_seq", 64'(araddr), 64'(m_ar_n * 4096));
        m_ar_n++;
        m_out++;
      end
      if (rvalid && rready && m_busy) begin
        expd = DW'(FD) + DW'(m_beat);
        m_bad = rdata != expd || rresp != 2'b00 || rlast != (m_beat % CPB == CPB - 1);
        if (m_bad) begin
          if (m_err == '0) m_first = AW'(m_beat * (DW / 8));
          if (m_err != '1) m_err++;
        end
        if (m_beat % CPB == CPB - 1) m_out--;
        m_beat++;
        if (m_beat == TOT) m_done_at = ncyc + 2;
      end
      stall_q = arvalid && !arready;
      addr_q = araddr;
      if (start && !m_busy && ncyc != m_done_at) begin
        m_busy = 1'b1; m_pass = 1'b0; m_err = '0; m_first = '0;
        m_beat = 0; m_ar_n = 0; m_dones = 0;
      end
    end
  end
  task automatic pulse_start();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask
  task automatic run_pass(input string tag);
    int n = 0;
    pulse_start();
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40000);
    chk({tag, "_done_seen"}, 64'(done), 64'(1));
    repeat (4) @(negedge clk);
    chk({tag, "_done_count"}, 64'(m_dones), 64'(1));
    chk({tag, "_beats"}, 64'(m_beat), 64'(TOT));
    chk({tag, "_bursts"}, 64'(m_ar_n), 64'(NB));
  endtask
  task automatic wait_beats(input int n);
    int k = 0;
    while (m_beat < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("reach_beat_%0d", n), 64'(m_beat >= n), 64'(1));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    slave_rst = 1'b0;
    @(negedge clk);
    chk("arlen", 64'(arlen), 64'(63));
    chk("arsize", 64'(arsize), 64'(6));
    chk("arburst", 64'(arburst), 64'(1));
    chk("ar_zero_fields", 64'({arid, arcache, arqos, arlock, arprot}), 64'(0));
    chk("reset_outputs", 64'({busy, done, pass, arvalid, error_count, first_err_addr, araddr}), 64'(0));
    run_pass("clean");
    chk("clean_pass", 64'(pass), 64'(1));
    chk("clean_errs", 64'(error_count), 64'(0));
    chk("clean_first", 64'(first_err_addr), 64'(0));
    bad_data_addr = 'h10040;
    run_pass("corrupt");
    chk("corrupt_pass", 64'(pass), 64'(0));
    chk("corrupt_errs", 64'(error_count), 64'(1));
    chk("corrupt_first", 64'(first_err_addr), 64'(20'h10040));
    chk("corrupt_model_first", 64'(m_first), 64'(20'h10040));
    bad_resp_addr = 'h20000;
    bad_data_addr = 'h30000;
    run_pass("rresp");
    chk("rresp_pass", 64'(pass), 64'(0));
    chk("rresp_errs", 64'(error_count), 64'(2));
    chk("rresp_first", 64'(first_err_addr), 64'(20'h20000));
    bad_resp_addr = -1;
    bad_data_addr = 'h100;
    pulse_start();
    wait_beats(3000);
    pulse_start();
    chk("mid_start_busy", 64'(busy), 64'(1));
    wait_beats(5000);
    chk("abort_errs", 64'(error_count), 64'(1));
    chk("abort_first", 64'(first_err_addr), 64'(20'h100));
    @(posedge clk);
    #2 resetn = 1'b0;
    slave_rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_errs", 64'(error_count), 64'(0));
    chk("rst_first", 64'(first_err_addr), 64'(0));
    chk("rst_arvalid", 64'(arvalid), 64'(0));
    chk("rst_araddr", 64'(araddr), 64'(0));
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    slave_rst = 1'b0;
    bad_data_addr = -1;
    ready_pct = 30;
    r_delay = 50;
    repeat (5) @(negedge clk);
    chk("no_done_after_abort", 64'(m_dones), 64'(0));
    run_pass("throttled");
    chk("throttled_pass", 64'(pass), 64'(1));
    chk("throttled_errs", 64'(error_count), 64'(0));
    ready_pct = 100;
    r_delay = 0;
    chk_out = 1'b0;
    early_last_addr = 'h280;
    run_pass("early_last");
    chk("early_last_pass", 64'(pass), 64'(0));
    chk("early_last_errs", 64'(error_count), 64'(1));
    chk("early_last_first", 64'(first_err_addr), 64'(20'h280));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
